// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: load align/extend, rdata hold, WB and forwarding buses
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   EXE_to_MEM_BUS[108:0] {pc, gr_we, dest, exe_result, mem_sum, mem_en, load_op, rfrom_mem}
//   EXE_to_MEM_valid      execute offers an instruction
//   MEM_allowin           this stage can accept an instruction
//   data_sram_rdata       SRAM read word for the request issued last cycle
//   WB_allowin            write-back can accept
//   MEM_to_WB_valid       instruction offered to write-back
//   MEM_to_WB_BUS[69:0]   {pc, gr_we, dest, final_result}
//   MEM_RF_BUS[37:0]      {dest_fwd, rfrom_mem, final_result} for decode forwarding/hazards

module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic [108:0] EXE_to_MEM_BUS,
    input  logic         EXE_to_MEM_valid,
    output logic         MEM_allowin,
    input  logic [31:0]  data_sram_rdata,
    input  logic         WB_allowin,
    output logic         MEM_to_WB_valid,
    output logic [69:0]  MEM_to_WB_BUS,
    output logic [37:0]  MEM_RF_BUS
);

    logic         mem_valid;
    logic [108:0] bus_r;
    logic [31:0]  rdata_buf;
    logic         rdata_held;

    logic         mem_ready_go;
    logic [31:0]  pc;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  exe_result;
    logic [31:0]  mem_sum;
    logic         mem_en;
    logic [4:0]   load_op;
    logic         rfrom_mem;

    logic [31:0]  rdata;
    logic [1:0]   off;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [31:0]  load_data;
    logic [31:0]  final_result;
    logic [4:0]   dest_fwd;
    logic         unused_fields;

    assign pc         = bus_r[108:77];
    assign gr_we      = bus_r[76];
    assign dest       = bus_r[75:71];
    assign exe_result = bus_r[70:39];
    assign mem_sum    = bus_r[38:7];
    assign mem_en     = bus_r[6];
    assign load_op    = bus_r[5:1];
    assign rfrom_mem  = bus_r[0];

    // Store address/enable travel with the instruction but no result depends on them.
    assign unused_fields = ^{mem_sum, mem_en};

    assign mem_ready_go    = 1'b1;
    assign MEM_allowin     = !mem_valid || (mem_ready_go && WB_allowin);
    assign MEM_to_WB_valid = mem_valid && mem_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid  <= 1'b0;
            bus_r      <= '0;
            rdata_buf  <= '0;
            rdata_held <= 1'b0;
        end else begin
            if (MEM_allowin) begin
                mem_valid <= EXE_to_MEM_valid;
            end
            if (EXE_to_MEM_valid && MEM_allowin) begin
                bus_r <= EXE_to_MEM_BUS;
            end
            // Not allowing in means a valid instruction is stalled by write-back.
            // Snapshot the SRAM word on the first stalled cycle only: afterwards
            // execute may already be driving a new request onto the SRAM.
            if (MEM_allowin) begin
                rdata_held <= 1'b0;
            end else if (!rdata_held) begin
                rdata_buf  <= data_sram_rdata;
                rdata_held <= 1'b1;
            end
        end
    end

    assign rdata = rdata_held ? rdata_buf : data_sram_rdata;
    assign off   = exe_result[1:0];

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Misaligned halfwords are not trapped; off[0] simply has no effect.
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = 32'd0;
        if (load_op[4]) begin
            load_data = rdata;
        end else if (load_op[3]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (load_op[2]) begin
            load_data = {16'd0, half_sel};
        end else if (load_op[1]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op[0]) begin
            load_data = {24'd0, byte_sel};
        end
    end

    assign final_result = rfrom_mem ? load_data : exe_result;
    assign dest_fwd     = (gr_we && mem_valid) ? dest : 5'd0;

    assign MEM_to_WB_BUS = {pc, gr_we, dest, final_result};
    assign MEM_RF_BUS    = {dest_fwd, rfrom_mem, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage (directed steps plus randomized model comparison)

module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic [108:0] e_bus;
    logic         e_valid;
    logic         allowin;
    logic [31:0]  rdata;
    logic         wb_in;
    logic         wb_valid;
    logic [69:0]  wb_bus;
    logic [37:0]  rf_bus;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .EXE_to_MEM_BUS   (e_bus),
        .EXE_to_MEM_valid (e_valid),
        .MEM_allowin      (allowin),
        .data_sram_rdata  (rdata),
        .WB_allowin       (wb_in),
        .MEM_to_WB_valid  (wb_valid),
        .MEM_to_WB_BUS    (wb_bus),
        .MEM_RF_BUS       (rf_bus)
    );

    always #5 clk = ~clk;

    // Reference model: which instruction occupies the stage, whether this is its
    // first cycle there, and the SRAM word it saw on that first cycle.
    logic         m_valid;
    logic [108:0] m_bus;
    logic         m_first;
    logic [31:0]  m_word;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [108:0] mk(input logic [31:0] pc, input logic g, input logic [4:0] d,
                                        input logic [31:0] exe, input logic [4:0] op, input logic rf);
        logic [31:0] ms;
        logic        me;
        ms = $urandom();
        me = 1'($urandom_range(0, 1));
        return {pc, g, d, exe, ms, me, op, rf};
    endfunction

    function automatic logic [31:0] ref_final(input logic [108:0] b, input logic [31:0] word);
        logic [31:0] exe;
        logic [4:0]  op;
        logic [31:0] v;
        int          off;
        exe = b[70:39];
        op  = b[5:1];
        off = int'(exe[1:0]);
        if (!b[0]) return exe;
        if (op == 5'b10000) return word;
        if (op == 5'b01000 || op == 5'b00100) begin
            v = (off >= 2) ? (word >> 16) : (word & 32'hFFFF);
            if (op == 5'b01000 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            return v;
        end
        if (op == 5'b00010 || op == 5'b00001) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (op == 5'b00010 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            return v;
        end
        return 32'd0;
    endfunction

    task automatic put(input logic v, input logic [108:0] b, input logic [31:0] rd, input logic wb);
        e_valid = v;
        e_bus   = b;
        rdata   = rd;
        wb_in   = wb;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_bus   = '0;
        m_first = 1'b1;
        m_word  = '0;
    endtask

    // Compare all outputs against the model mid-cycle.
    task automatic at_neg();
        logic [31:0] word;
        logic [31:0] fin;
        @(negedge clk);
        word = (m_valid && !m_first) ? m_word : rdata;
        fin  = ref_final(m_bus, word);
        chk("allowin",  128'(allowin),  128'(!m_valid || wb_in));
        chk("wb_valid", 128'(wb_valid), 128'(m_valid));
        chk("wb_bus",   128'(wb_bus),   128'({m_bus[108:77], m_bus[76], m_bus[75:71], fin}));
        chk("rf_bus",   128'(rf_bus),
            128'({(m_bus[76] && m_valid) ? m_bus[75:71] : 5'd0, m_bus[0], fin}));
    endtask

    task automatic edge_step();
        logic allow;
        if (!resetn) begin
            model_reset();
        end else begin
            allow = !m_valid || wb_in;
            if (m_valid && !allow && m_first) begin
                m_word  = rdata;
                m_first = 1'b0;
            end
            if (allow) begin
                m_valid = e_valid;
                if (e_valid) m_bus = e_bus;
                m_first = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [69:0] saved;
    logic [4:0]  op;
    int          k;

    initial begin
        resetn = 1'b0;
        put(1'b0, '0, 32'd0, 1'b1);
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        at_neg();
        chk("rst_allowin", 128'(allowin), 128'(1'b1));
        chk("rst_valid", 128'(wb_valid), 128'(1'b0));
        chk("rst_wb_bus", 128'(wb_bus), 128'(0));
        chk("rst_rf_bus", 128'(rf_bus), 128'(0));
        edge_step();
        resetn = 1'b1;

        // LD_B, offset 3, negative byte
        put(1'b1, mk(32'h100, 1'b1, 5'd5, 32'h1003, 5'b00010, 1'b1), 32'd0, 1'b1);
        at_neg(); edge_step();
        put(1'b0, '0, 32'h80FF_1234, 1'b1);
        at_neg();
        chk("ldb_result", 128'(wb_bus[31:0]), 128'(32'hFFFF_FF80));
        chk("ldb_we_dest", 128'(wb_bus[37:32]), 128'(6'b1_00101));
        chk("ldb_rfrom", 128'(rf_bus[32]), 128'(1'b1));
        chk("ldb_pc", 128'(wb_bus[69:38]), 128'(32'h100));
        edge_step();

        // LD_HU and LD_H, offset 2
        put(1'b1, mk(32'h104, 1'b1, 5'd6, 32'h2002, 5'b00100, 1'b1), 32'd0, 1'b1);
        at_neg(); edge_step();
        put(1'b1, mk(32'h108, 1'b1, 5'd7, 32'h2002, 5'b01000, 1'b1), 32'h9ABC_0000, 1'b1);
        at_neg();
        chk("ldhu_result", 128'(wb_bus[31:0]), 128'(32'h0000_9ABC));
        edge_step();
        put(1'b0, '0, 32'h9ABC_0000, 1'b1);
        at_neg();
        chk("ldh_result", 128'(wb_bus[31:0]), 128'(32'hFFFF_9ABC));
        edge_step();

        // LD_W then 3 stall cycles while the SRAM word changes
        put(1'b1, mk(32'h10C, 1'b1, 5'd8, 32'h3000, 5'b10000, 1'b1), 32'd0, 1'b1);
        at_neg(); edge_step();
        put(1'b0, '0, 32'h1234_5678, 1'b0);
        at_neg();
        chk("stall_first", 128'(wb_bus[31:0]), 128'(32'h1234_5678));
        chk("stall_allowin", 128'(allowin), 128'(1'b0));
        saved = wb_bus;
        edge_step();
        for (int i = 0; i < 2; i++) begin
            put(1'b1, mk(32'h200, 1'b1, 5'd9, 32'h44, 5'b0, 1'b0), 32'hDEAD_BEEF, 1'b0);
            at_neg();
            chk("stall_hold", 128'(wb_bus), 128'(saved));
            chk("stall_valid", 128'(wb_valid), 128'(1'b1));
            edge_step();
        end
        put(1'b0, '0, 32'hDEAD_BEEF, 1'b1);
        at_neg();
        chk("stall_release", 128'(wb_bus), 128'(saved));
        chk("release_allowin", 128'(allowin), 128'(1'b1));
        edge_step();

        // Back-to-back ALU ops
        for (int i = 0; i < 3; i++) begin
            put(1'b1, mk(32'h40 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(8'h11 * (i + 1)), 5'b0, 1'b0),
                $urandom(), 1'b1);
            at_neg();
            chk("b2b_allowin", 128'(allowin), 128'(1'b1));
            if (i > 0) begin
                chk("b2b_valid", 128'(wb_valid), 128'(1'b1));
                chk("b2b_result", 128'(wb_bus[31:0]), 128'(32'(8'h11 * i)));
            end
            edge_step();
        end
        put(1'b0, '0, $urandom(), 1'b1);
        at_neg();
        chk("b2b_last", 128'(wb_bus[31:0]), 128'(32'h33));
        chk("b2b_last_valid", 128'(wb_valid), 128'(1'b1));
        edge_step();
        at_neg();
        chk("bubble_valid", 128'(wb_valid), 128'(1'b0));
        chk("bubble_fwd", 128'(rf_bus[37:33]), 128'(5'd0));
        edge_step();

        // gr_we = 0 suppresses the forwarded destination
        put(1'b1, mk(32'h300, 1'b0, 5'd7, 32'h55, 5'b0, 1'b0), 32'd0, 1'b1);
        at_neg(); edge_step();
        put(1'b0, '0, 32'd0, 1'b1);
        at_neg();
        chk("nowe_fwd", 128'(rf_bus[37:33]), 128'(5'd0));
        edge_step();

        // Reset during a stalled load
        put(1'b1, mk(32'h400, 1'b1, 5'd10, 32'h5001, 5'b00001, 1'b1), 32'd0, 1'b1);
        at_neg(); edge_step();
        put(1'b0, '0, 32'hCAFE_F00D, 1'b0);
        at_neg(); edge_step();
        resetn = 1'b0;
        at_neg(); edge_step();
        resetn = 1'b1;
        at_neg();
        chk("midrst_valid", 128'(wb_valid), 128'(1'b0));
        chk("midrst_allowin", 128'(allowin), 128'(1'b1));
        chk("midrst_wb_bus", 128'(wb_bus), 128'(0));
        chk("midrst_rf_bus", 128'(rf_bus), 128'(0));
        edge_step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            k  = int'($urandom_range(0, 5));
            op = (k == 0) ? 5'd0 : 5'(1 << (k - 1));
            put(1'($urandom_range(0, 1)),
                mk($urandom(), 1'($urandom_range(0, 1)), 5'($urandom()), $urandom(), op, op != 5'd0),
                $urandom(), ($urandom_range(0, 2) != 0));
            resetn = ($urandom_range(0, 49) != 0);
            at_neg();
            edge_step();
        end
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
